// File: rtl/fp_div_issue.sv
// fp_div_issue: flow-control / special-case stage around the free-running fpDiv core.
// Operand pairs are accepted on a valid/ready handshake and registered into the core.
// A tag pipeline follows each pair through the core latency. Results are buffered in a
// show-ahead FIFO, and a credit counter keeps that FIFO from overflowing.
// Optional feature macro: FP_DIV_ISSUE_SPECIAL_EN enables IEEE-754 special-case override
// and the {div_by_zero, invalid} flags. With the macro undefined, out_flags is always 0.
module fp_div_issue #(
    parameter int LATENCY = 28,
    parameter int DEPTH   = 4
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value1,
    input  logic [31:0] in_value2,
    output logic [31:0] div_value1,
    output logic [31:0] div_value2,
    input  logic [31:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_flags
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = PW + 1;               // extra wrap bit distinguishes full from empty
    localparam int CW = $clog2(DEPTH + 1);

`ifdef FP_DIV_ISSUE_SPECIAL_EN
    typedef struct packed {
        logic        valid;
        logic        special;
        logic [1:0]  flags;
        logic [31:0] special_value;
    } tag_t;

    typedef struct packed {
        logic [31:0] result;
        logic [1:0]  flags;
    } entry_t;
`else
    typedef struct packed {
        logic valid;
    } tag_t;

    typedef struct packed {
        logic [31:0] result;
    } entry_t;
`endif

    logic          in_hs, out_hs, wr_en;
    logic [CW-1:0] credits_q, credits_d;
    logic [31:0]   div_value1_q, div_value1_d, div_value2_q, div_value2_d;
    tag_t          tag_in;
    tag_t          tag_q [LATENCY];
    tag_t          tag_d [LATENCY];
    tag_t          tag_out;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        wr_entry, rd_entry;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // in_ready comes only from the registered credit count, so nothing from out_ready leaks in
    assign in_ready = (credits_q != CW'(DEPTH)) && !reset;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    assign div_value1 = div_value1_q;
    assign div_value2 = div_value2_q;

    // Credit bookkeeping: one credit per outstanding operation (in flight or buffered)
    always_comb begin
        credits_d = credits_q;
        if (in_hs && !out_hs) begin
            credits_d = credits_q + CW'(1);
        end else if (!in_hs && out_hs) begin
            credits_d = credits_q - CW'(1);
        end
    end

    // Operand registers feeding the core; hold when nothing is accepted
    always_comb begin
        div_value1_d = in_hs ? in_value1 : div_value1_q;
        div_value2_d = in_hs ? in_value2 : div_value2_q;
    end

`ifdef FP_DIV_ISSUE_SPECIAL_EN
    logic a_zero, a_fin, a_inf, a_nan, b_zero, b_fin, b_inf, b_nan, q_sign;

    assign a_zero = (in_value1[30:0] == 31'd0);
    assign a_fin  = (in_value1[30:23] != 8'hFF);
    assign a_inf  = !a_fin && (in_value1[22:0] == 23'd0);
    assign a_nan  = !a_fin && (in_value1[22:0] != 23'd0);
    assign b_zero = (in_value2[30:0] == 31'd0);
    assign b_fin  = (in_value2[30:23] != 8'hFF);
    assign b_inf  = !b_fin && (in_value2[22:0] == 23'd0);
    assign b_nan  = !b_fin && (in_value2[22:0] != 23'd0);
    assign q_sign = in_value1[31] ^ in_value2[31];

    // Classify the incoming pair; the first matching rule wins
    always_comb begin
        tag_in       = '0;
        tag_in.valid = in_hs;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            tag_in.special       = 1'b1;
            tag_in.flags         = 2'b01;
            tag_in.special_value = 32'h7FC0_0000;
        end else if (a_fin && !a_zero && b_zero) begin
            tag_in.special       = 1'b1;
            tag_in.flags         = 2'b10;
            tag_in.special_value = {q_sign, 8'hFF, 23'd0};
        end else if (a_inf && b_fin) begin
            tag_in.special       = 1'b1;
            tag_in.special_value = {q_sign, 8'hFF, 23'd0};
        end else if (a_fin && b_inf) begin
            tag_in.special       = 1'b1;
            tag_in.special_value = {q_sign, 31'd0};
        end else if (a_zero && b_fin) begin
            // 0/0 was already taken by the invalid rule, so the divisor here is non-zero
            tag_in.special       = 1'b1;
            tag_in.special_value = {q_sign, 31'd0};
        end
    end
`else
    // Without special-case handling the tag only marks a live operation
    always_comb begin
        tag_in       = '0;
        tag_in.valid = in_hs;
    end
`endif

    // Tag shift register kept in lock-step with the core pipeline
    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out = tag_q[LATENCY-1];
    assign wr_en   = tag_out.valid;

    // Select the FIFO write word: core quotient unless the tag carries an override
    always_comb begin
        wr_entry        = '0;
        wr_entry.result = div_result;
`ifdef FP_DIV_ISSUE_SPECIAL_EN
        wr_entry.flags  = tag_out.flags;
        if (tag_out.special) begin
            wr_entry.result = tag_out.special_value;
        end
`endif
    end

    // FIFO pointer and storage update; credits guarantee no write while full
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[PW-1:0]] = wr_entry;
            wr_ptr_d                = wr_ptr_q + AW'(1);
        end
        if (out_hs) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    assign out_valid  = (wr_ptr_q != rd_ptr_q);
    assign rd_entry   = mem_q[rd_ptr_q[PW-1:0]];
    // Gate with out_valid so an empty FIFO shows zeros rather than stale data
    assign out_result = out_valid ? rd_entry.result : 32'd0;
`ifdef FP_DIV_ISSUE_SPECIAL_EN
    assign out_flags  = out_valid ? rd_entry.flags : 2'b00;
`else
    assign out_flags  = 2'b00;
`endif

    // Control state with synchronous reset; reset discards everything in flight
    always_ff @(posedge aclk) begin
        if (reset) begin
            credits_q    <= '0;
            div_value1_q <= '0;
            div_value2_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            credits_q    <= credits_d;
            div_value1_q <= div_value1_d;
            div_value2_q <= div_value2_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // FIFO storage needs no reset: pointers alone decide what is valid
    always_ff @(posedge aclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_fp_div_issue.sv
// Testbench for fp_div_issue: stand-in fpDiv core, scoreboard queue filled on accept and
// drained by an independent monitor, directed timing checks plus randomized traffic.
module tb_fp_div_issue;
    localparam int LATENCY = 28;
    localparam int DEPTH   = 4;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_value1 = '0;
    logic [31:0] in_value2 = '0;
    logic        in_ready, out_valid;
    logic [31:0] div_value1, div_value2, div_result, out_result;
    logic [1:0]  out_flags;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] sbq[$];

    fp_div_issue #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value1(in_value1), .in_value2(in_value2),
        .div_value1(div_value1), .div_value2(div_value2), .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 aclk = ~aclk;

    // Stand-in core: known quotients for the directed pairs, a scrambling hash otherwise
    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h3FC00000}: return 32'h3F800000;
            {32'hC0600000, 32'h40200000}: return 32'hBFB33333;
            {32'h3F800000, 32'h00000000}: return 32'h7F800000;
            {32'h00000000, 32'h00000000}: return 32'hFFC00000;
            {32'hBF800000, 32'h7F800000}: return 32'h80000000;
            default: return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A1234;
        endcase
    endfunction

    // Core model: result for operands presented after edge k is visible up to edge k+LATENCY
    logic [31:0] core_pipe [LATENCY-1];
    always @(posedge aclk) begin
        core_pipe[0] <= core_fn(div_value1, div_value2);
        for (int i = 1; i < LATENCY - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign div_result = core_pipe[LATENCY-2];

    // Reference: {flags, result} for a pair, straight from the IEEE special-case rules
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_DIV_ISSUE_SPECIAL_EN
        bit az = (a[30:0] == 0), bz = (b[30:0] == 0);
        bit ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bit bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        bit an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bit bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        bit af = !ai && !an, bf = !bi && !bn;
        logic s = a[31] ^ b[31];
        if (an || bn || (az && bz) || (ai && bi)) return {2'b01, 32'h7FC00000};
        if (af && !az && bz)                    return {2'b10, s, 8'hFF, 23'd0};
        if (ai && bf)                           return {2'b00, s, 8'hFF, 23'd0};
        if (af && bi)                           return {2'b00, s, 31'd0};
        if (az && bf)                           return {2'b00, s, 31'd0};
        return {2'b00, core_fn(a, b)};
`else
        return {2'b00, core_fn(a, b)};
`endif
    endfunction

    function automatic logic [31:0] rand_fp();
        int         cls = $urandom_range(0, 6);
        logic       s   = 1'($urandom_range(0, 1));
        logic [22:0] fr = 23'($urandom);
        case (cls)
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, fr | 23'd1};
            3: return {s, 8'h00, fr | 23'd1};
            default: return {s, 8'($urandom_range(1, 254)), fr};
        endcase
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: sampled at negedge, away from the active edge
    always @(negedge aclk) begin
        if (reset) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {2'b00, out_result}, 34'd0);
                end else begin
                    logic [33:0] e;
                    e = sbq.pop_front();
                    chk("out_result", {2'b00, out_result}, {2'b00, e[31:0]});
                    chk("out_flags", {32'd0, out_flags}, {32'd0, e[33:32]});
                end
            end
            if (in_valid && in_ready) sbq.push_back(ref_div(in_value1, in_value2));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && n < LATENCY + 4 * DEPTH + 20) begin
            tick();
            n++;
        end
        chk("drain_empty", {33'd0, (sbq.size() == 0 && !out_valid)}, 34'd1);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < LATENCY + 10) begin
            tick();
            n++;
        end
        chk("out_valid_seen", {33'd0, out_valid}, 34'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pa [6];
        logic [31:0] pb [6];
        int cnt, acc, bad;
        pa[0] = 32'hC0600000; pb[0] = 32'h40200000;
        pa[1] = 32'h3F800000; pb[1] = 32'h00000000;
        pa[2] = 32'h00000000; pb[2] = 32'h00000000;
        pa[3] = 32'hBF800000; pb[3] = 32'h7F800000;
        pa[4] = 32'h3FC00000; pb[4] = 32'h3FC00000;
        pa[5] = 32'h40000000; pb[5] = 32'h40400000;

        // Reset state
        reset = 1'b1;
        tick(); tick(); tick();
        chk("rst_in_ready", {33'd0, in_ready}, 34'd0);
        chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
        chk("rst_out_result", {2'b00, out_result}, 34'd0);
        chk("rst_out_flags", {32'd0, out_flags}, 34'd0);
        chk("rst_div_value1", {2'b00, div_value1}, 34'd0);
        chk("rst_div_value2", {2'b00, div_value2}, 34'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {33'd0, in_ready}, 34'd1);

        // Latency of a single 1.5/1.5 with an idle pipeline
        out_ready = 1'b1;
        in_valid = 1'b1; in_value1 = 32'h3FC00000; in_value2 = 32'h3FC00000;
        tick();
        in_valid = 1'b0;
        chk("div_value1_load", {2'b00, div_value1}, {2'b00, 32'h3FC00000});
        cnt = 0;
        while (!out_valid && cnt < LATENCY + 10) begin
            tick();
            cnt++;
        end
        chk("latency", 34'(cnt), 34'(LATENCY));
        drain();

        // Directed pairs back to back
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_value1 = pa[i]; in_value2 = pb[i];
            tick();
        end
        drain();

        // Backpressure: at most DEPTH accepted with the consumer stalled
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid  = (acc < 6);
            in_value1 = pa[acc % 6];
            in_value2 = pb[acc % 6];
            #1;
            if (in_valid && in_ready) acc++;
            tick();
        end
        chk("bp_accepted", 34'(acc), 34'(DEPTH));
        chk("bp_in_ready_low", {33'd0, in_ready}, 34'd0);
        in_valid = 1'b0;
        wait_out_valid();
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", {33'd0, in_ready}, 34'd0);
        tick();
        chk("bp_ready_reassert", {33'd0, in_ready}, 34'd1);
        drain();

        // Reset with 3 operations outstanding
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_value1 = pa[i]; in_value2 = pb[i];
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < LATENCY + 2; c++) begin
            #1;
            if (out_valid) bad++;
            tick();
        end
        chk("rst_mid_no_output", 34'(bad), 34'd0);
        chk("rst_mid_in_ready", {33'd0, in_ready}, 34'd1);

        // Simultaneous in/out handshake at credits=3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_value1 = pa[i + 3]; in_value2 = pb[i + 3];
            tick();
        end
        in_valid = 1'b0;
        wait_out_valid();
        in_valid = 1'b1; in_value1 = pa[0]; in_value2 = pb[0];
        out_ready = 1'b1;
        #1;
        chk("c3_in_ready", {33'd0, in_ready}, 34'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("c3_still_ready", {33'd0, in_ready}, 34'd1);
        in_valid = 1'b1; in_value1 = pa[1]; in_value2 = pb[1];
        tick();
        in_valid = 1'b0;
        chk("c4_full", {33'd0, in_ready}, 34'd0);
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_value1 = rand_fp();
            in_value2 = rand_fp();
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        chk("final_in_ready", {33'd0, in_ready}, 34'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
